// File: rtl/xt_ram_bridge_pkg.sv
// Shared types and constants for the xt_ram_bridge bus-to-RAM bridge.
package xt_ram_bridge_pkg;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Value returned on a read that timed out waiting for the RAM.
   localparam logic [DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

   function automatic logic odd_parity(input logic [DATA_W-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/xt_ram_bridge.sv
// Bridges strobe-based system bus memory cycles onto a request/ack RAM port with wait states and timeout.
// Optional macro XT_RAM_BRIDGE_PARITY_EN enables odd-parity generation/checking and the sticky io_channel_check flag.
module xt_ram_bridge
   import xt_ram_bridge_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAM_TOP        = 20'hA0000,
   parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 8'd255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_bus,
   input  logic              memory_read_n,
   input  logic              memory_write_n,
   output logic              io_channel_ready,
   output logic              io_channel_check,
   input  logic              parity_clear,
   output logic [DATA_W-1:0] data_bus_out,
   output logic              data_bus_out_enable,
   output logic              ram_request,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_write_data,
   output logic              ram_write_parity,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_read_data,
   input  logic              ram_read_parity
);

   state_t            state;
   state_t            state_next;
   logic              rd_q;
   logic              wr_q;
   logic              released_q;
   logic [CNT_W-1:0]  wait_cnt;

   logic              rd_fall;
   logic              wr_fall;
   logic              start;
   logic              strobe_high;
   logic              gone;
   logic              timeout;

   logic              ready_d;
   logic              req_d;
   logic              write_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              wpar_d;
   logic [DATA_W-1:0] dout_d;
   logic              en_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              released_d;
   logic              chk_d;
   logic              wpar_new;

   // A cycle begins on a clean falling edge of exactly one strobe inside the window.
   assign rd_fall     = rd_q & ~memory_read_n & memory_write_n;
   assign wr_fall     = wr_q & ~memory_write_n & memory_read_n;
   assign start       = (state == IDLE) && (rd_fall || wr_fall) && (address < RAM_TOP);
   assign strobe_high = ram_write ? memory_write_n : memory_read_n;
   assign gone        = released_q | strobe_high;
   assign timeout     = (wait_cnt == TIMEOUT_CYCLES);

`ifdef XT_RAM_BRIDGE_PARITY_EN
   logic par_err;
   assign par_err  = (state == REQ) && ram_ack && !ram_write &&
                     (ram_read_parity != odd_parity(ram_read_data));
   assign chk_d    = parity_clear ? 1'b0 : (io_channel_check | par_err);
   assign wpar_new = odd_parity(data_bus);
`else
   logic unused_parity;
   assign unused_parity = ^{ram_read_parity, parity_clear};
   assign chk_d         = 1'b0;
   assign wpar_new      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; an ack after a strobe release skips the data phase.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = REQ;
         REQ: begin
            if (ram_ack)      state_next = gone ? IDLE : HOLD;
            else if (timeout) state_next = HOLD;
         end
         HOLD: if (strobe_high) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output/datapath next values.
   always_comb begin
      ready_d    = io_channel_ready;
      req_d      = ram_request;
      write_d    = ram_write;
      addr_d     = ram_address;
      wdata_d    = ram_write_data;
      wpar_d     = ram_write_parity;
      dout_d     = data_bus_out;
      cnt_d      = wait_cnt;
      released_d = released_q;
      case (state)
         IDLE: begin
            if (start) begin
               req_d      = 1'b1;
               ready_d    = 1'b0;
               write_d    = wr_fall;
               addr_d     = address;
               wdata_d    = data_bus;
               wpar_d     = wpar_new;
               cnt_d      = '0;
               released_d = 1'b0;
            end
         end
         REQ: begin
            released_d = released_q | strobe_high;
            if (ram_ack) begin
               req_d   = 1'b0;
               ready_d = 1'b1;
               if (!ram_write) dout_d = ram_read_data;
            end else if (timeout) begin
               req_d   = 1'b0;
               ready_d = 1'b1;
               dout_d  = OPEN_BUS_DATA;
            end else begin
               cnt_d = wait_cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
      en_d = (state_next == HOLD) && !ram_write && !memory_read_n;
   end

   // Registered outputs, strobe history and wait counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q                <= 1'b1;
         wr_q                <= 1'b1;
         released_q          <= 1'b0;
         wait_cnt            <= '0;
         io_channel_ready    <= 1'b1;
         io_channel_check    <= 1'b0;
         data_bus_out        <= '0;
         data_bus_out_enable <= 1'b0;
         ram_request         <= 1'b0;
         ram_write           <= 1'b0;
         ram_address         <= '0;
         ram_write_data      <= '0;
         ram_write_parity    <= 1'b0;
      end else begin
         rd_q                <= memory_read_n;
         wr_q                <= memory_write_n;
         released_q          <= released_d;
         wait_cnt            <= cnt_d;
         io_channel_ready    <= ready_d;
         io_channel_check    <= chk_d;
         data_bus_out        <= dout_d;
         data_bus_out_enable <= en_d;
         ram_request         <= req_d;
         ram_write           <= write_d;
         ram_address         <= addr_d;
         ram_write_data      <= wdata_d;
         ram_write_parity    <= wpar_d;
      end
   end

endmodule

// File: tb/tb_xt_ram_bridge.sv
// Self-checking bench for xt_ram_bridge: scoreboard queues hold expected read data and write requests.
module tb_xt_ram_bridge;
   import xt_ram_bridge_pkg::*;

   localparam logic [19:0] TOP    = 20'hA0000;
   localparam logic [7:0]  TMO    = 8'd255;
   localparam int          BUDGET = 400;
`ifdef XT_RAM_BRIDGE_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] address = '0;
   logic [7:0]  data_bus = '0;
   logic        memory_read_n = 1'b1;
   logic        memory_write_n = 1'b1;
   logic        parity_clear = 1'b0;
   logic        ram_ack = 1'b0;
   logic [7:0]  ram_read_data = '0;
   logic        ram_read_parity = 1'b0;
   logic        io_channel_ready, io_channel_check, data_bus_out_enable;
   logic        ram_request, ram_write, ram_write_parity;
   logic [7:0]  data_bus_out, ram_write_data;
   logic [19:0] ram_address;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  rd_exp_q[$];
   logic [27:0] wr_exp_q[$];
   logic        exp_chk = 1'b0;

   xt_ram_bridge dut (
      .clock(clock), .reset(reset), .address(address), .data_bus(data_bus),
      .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
      .io_channel_ready(io_channel_ready), .io_channel_check(io_channel_check),
      .parity_clear(parity_clear), .data_bus_out(data_bus_out),
      .data_bus_out_enable(data_bus_out_enable), .ram_request(ram_request),
      .ram_write(ram_write), .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_write_parity(ram_write_parity), .ram_ack(ram_ack),
      .ram_read_data(ram_read_data), .ram_read_parity(ram_read_parity)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic bus_read(input string tag, input logic [19:0] a, input int ack_dly,
                           input logic [7:0] rd, input logic rp, input int hold_cycles);
      int   n;
      int   low;
      logic timed_out;
      logic stable;
      logic [7:0] exp_d;
      timed_out = (ack_dly > int'(TMO));
      rd_exp_q.push_back(timed_out ? OPEN_BUS_DATA : rd);
      if (PAR_EN && !timed_out && (rp != ~^rd)) exp_chk = 1'b1;
      address = a;
      memory_read_n = 1'b0;
      tick();
      check_eq({tag, "_req"}, 32'(ram_request), 32'(1));
      check_eq({tag, "_addr"}, 32'(ram_address), 32'(a));
      n = 0;
      low = 0;
      while (!io_channel_ready && n < BUDGET) begin
         low++;
         ram_ack = (n == ack_dly);
         ram_read_data = rd;
         ram_read_parity = rp;
         tick();
         ram_ack = 1'b0;
         n++;
      end
      check_eq({tag, "_wait"}, 32'(low), timed_out ? 32'(int'(TMO) + 1) : 32'(ack_dly + 1));
      check_eq({tag, "_reqdrop"}, 32'(ram_request), 32'(0));
      check_eq({tag, "_chk"}, 32'(io_channel_check), 32'(exp_chk));
      check_eq({tag, "_en"}, 32'(data_bus_out_enable), 32'(1));
      exp_d = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 8'h00;
      check_eq({tag, "_data"}, 32'(data_bus_out), 32'(exp_d));
      stable = 1'b1;
      for (int i = 0; i < hold_cycles; i++) begin
         ram_ack = (n == ack_dly);
         ram_read_data = rd;
         tick();
         ram_ack = 1'b0;
         n++;
         stable &= data_bus_out_enable && (data_bus_out == exp_d) && !ram_request && io_channel_ready;
      end
      check_eq({tag, "_hold"}, 32'(stable), 32'(1));
      memory_read_n = 1'b1;
      tick();
      check_eq({tag, "_endoff"}, 32'(data_bus_out_enable), 32'(0));
   endtask

   task automatic bus_write(input string tag, input logic [19:0] a, input logic [7:0] d);
      int   n;
      logic hit;
      logic [27:0] exp;
      hit = (a < TOP);
      if (hit) wr_exp_q.push_back({a, d});
      address = a;
      data_bus = d;
      memory_write_n = 1'b0;
      tick();
      data_bus = ~d;
      if (hit) begin
         check_eq({tag, "_req"}, 32'(ram_request), 32'(1));
         exp = wr_exp_q.pop_front();
         check_eq({tag, "_wr"}, 32'(ram_write), 32'(1));
         check_eq({tag, "_addr"}, 32'(ram_address), 32'(exp[27:8]));
         check_eq({tag, "_par"}, 32'(ram_write_parity), PAR_EN ? 32'(~^d) : 32'(0));
         n = 0;
         while (!io_channel_ready && n < BUDGET) begin
            ram_ack = (n == 1);
            tick();
            ram_ack = 1'b0;
            n++;
         end
         check_eq({tag, "_wait"}, 32'(n), 32'(2));
         check_eq({tag, "_wdata"}, 32'(ram_write_data), 32'(exp[7:0]));
         check_eq({tag, "_en"}, 32'(data_bus_out_enable), 32'(0));
      end else begin
         tick();
         tick();
         check_eq({tag, "_noreq"}, 32'(ram_request), 32'(0));
         check_eq({tag, "_rdy"}, 32'(io_channel_ready), 32'(1));
      end
      memory_write_n = 1'b1;
      tick();
      check_eq({tag, "_idle"}, 32'({io_channel_ready, ram_request}), 32'(2'b10));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check_eq("rst_ready", 32'(io_channel_ready), 32'(1));
      check_eq("rst_req", 32'(ram_request), 32'(0));
      check_eq("rst_misc", 32'({io_channel_check, data_bus_out_enable, ram_write}), 32'(0));
      check_eq("rst_dout", 32'(data_bus_out), 32'(0));
      check_eq("rst_addr", 32'(ram_address), 32'(0));
      check_eq("rst_wdata", 32'(ram_write_data), 32'(0));
      reset = 1'b0;
      tick();

      bus_read("rd_basic", 20'h01234, 3, 8'h5A, 1'b1, 3);
      bus_write("wr_edge", 20'h9FFFF, 8'hC3);
      bus_write("wr_miss", 20'hA0000, 8'h3C);
      bus_read("rd_fast", 20'h9FFFF, 0, 8'h3C, 1'b1, 1);
      bus_read("rd_tmo", 20'h00000, 300, 8'h33, 1'b0, 50);

      bus_read("rd_perr", 20'h00010, 2, 8'h01, 1'b1, 1);
      bus_read("rd_sticky", 20'h00020, 1, 8'h80, 1'b0, 1);
      parity_clear = 1'b1;
      exp_chk = 1'b0;
      tick();
      parity_clear = 1'b0;
      check_eq("pclear", 32'(io_channel_check), 32'(exp_chk));

      // Strobe released while the RAM is still busy: no data phase.
      address = 20'h00300;
      memory_read_n = 1'b0;
      tick();
      memory_read_n = 1'b1;
      tick();
      tick();
      ram_ack = 1'b1;
      ram_read_data = 8'h77;
      tick();
      ram_ack = 1'b0;
      check_eq("rel_state", 32'({io_channel_ready, ram_request, data_bus_out_enable}), 32'(3'b100));
      tick();
      check_eq("rel_noen", 32'(data_bus_out_enable), 32'(0));

      // Both strobes low together.
      address = 20'h00100;
      memory_read_n = 1'b0;
      memory_write_n = 1'b0;
      repeat (3) tick();
      check_eq("both_noreq", 32'(ram_request), 32'(0));
      check_eq("both_rdy", 32'(io_channel_ready), 32'(1));
      memory_read_n = 1'b1;
      memory_write_n = 1'b1;
      tick();

      // Reset in the middle of a request.
      address = 20'h00200;
      memory_read_n = 1'b0;
      tick();
      check_eq("rstreq_req", 32'(ram_request), 32'(1));
      reset = 1'b1;
      memory_read_n = 1'b1;
      tick();
      exp_chk = 1'b0;
      check_eq("rstreq_drop", 32'({ram_request, io_channel_ready}), 32'(2'b01));
      reset = 1'b0;
      ram_ack = 1'b1;
      ram_read_data = 8'hEE;
      tick();
      ram_ack = 1'b0;
      tick();
      check_eq("rstreq_ign", 32'({ram_request, io_channel_ready, data_bus_out_enable}), 32'(3'b010));
      check_eq("rstreq_dout", 32'(data_bus_out), 32'(0));
      check_eq("rstreq_chk", 32'(io_channel_check), 32'(exp_chk));

      check_eq("sb_rd_empty", 32'(rd_exp_q.size()), 32'(0));
      check_eq("sb_wr_empty", 32'(wr_exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xt_ram_bridge.md
XT_RAM_BRIDGE -- requirements
Module: xt_ram_bridge

Interface
REQ-001 SHALL have parameter RAM_TOP, default 20'hA0000: exclusive upper address bound of the decoded memory window (base 0).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, width 8: cycles REQ may wait for ram_ack before aborting.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports named clock and reset.
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 address  in  20  system bus address.
REQ-007 data_bus  in  8  system bus write data.
REQ-008 memory_read_n  in  1  bus memory read strobe, active low.
REQ-009 memory_write_n  in  1  bus memory write strobe, active low.
REQ-010 io_channel_ready  out  1  1 = ready; 0 = insert wait states.
REQ-011 io_channel_check  out  1  sticky parity error flag to NMI logic.
REQ-012 parity_clear  in  1  one-cycle pulse clearing io_channel_check.
REQ-013 data_bus_out  out  8  read data returned to the bus.
REQ-014 data_bus_out_enable  out  1  1 = data_bus_out is valid and driven.
REQ-015 ram_request / ram_write  out  1 / 1  RAM access request; 1 = write.
REQ-016 ram_address / ram_write_data  out  20 / 8  RAM access address and write data.
REQ-017 ram_write_parity  out  1  odd parity bit stored with write data.
REQ-018 ram_ack  in  1  one-cycle pulse completing the pending RAM access.
REQ-019 ram_read_data / ram_read_parity  in  8 / 1  RAM read data and stored parity bit, valid with ram_ack.

Function
REQ-020 SHALL register both strobes each cycle; a cycle starts when the registered strobe is high and the current strobe is low, exactly one strobe is low, and address < RAM_TOP.
REQ-021 SHALL ignore the start condition when both strobes are low or when the address misses the window; all outputs hold idle values.
REQ-022 SHALL implement FSM IDLE -> REQ -> HOLD -> IDLE.
REQ-023 On a start condition: next cycle state=REQ, ram_request=1, io_channel_ready=0, ram_address/ram_write/ram_write_data latched from the start cycle.
REQ-024 In REQ: ram_request held 1 until the cycle ram_ack=1; the next cycle ram_request=0, io_channel_ready=1, state=HOLD.
REQ-025 A read SHALL latch ram_read_data into data_bus_out on the ram_ack cycle.
REQ-026 In HOLD, data_bus_out_enable SHALL be 1 while memory_read_n=0 for read cycles; it is 0 for write cycles.
REQ-027 HOLD -> IDLE the cycle after the active strobe is seen high; data_bus_out_enable=0 that cycle.
REQ-028 Strobe released during REQ: remain in REQ until ram_ack, then go directly to IDLE with no data drive.
REQ-029 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-030 At count == TIMEOUT_CYCLES without ram_ack: ram_request=0, io_channel_ready=1, data_bus_out=8'hFF, state=HOLD.
REQ-031 A late ram_ack after a timeout SHALL be ignored.
REQ-032 New start conditions SHALL be ignored outside IDLE.

Reset
REQ-033 Reset SHALL force state=IDLE, io_channel_ready=1, io_channel_check=0, data_bus_out=8'h00, data_bus_out_enable=0, ram_request=0, ram_write=0, ram_address=0, ram_write_data=0, wait counter=0, and registered strobes=1.
REQ-034 Reset mid-REQ SHALL drop ram_request immediately; any following ram_ack SHALL be ignored.

Configuration
REQ-035 With macro XT_RAM_BRIDGE_PARITY_EN defined:
  - ram_write_parity = ~^ram_write_data (odd parity).
  - On a read ram_ack, mismatch of ram_read_parity sets io_channel_check=1 the next cycle.
  - io_channel_check stays 1 until parity_clear=1 or reset; parity_clear has priority over a simultaneous set.
REQ-036 Without the macro: ram_write_parity=0, io_channel_check=0, ram_read_parity and parity_clear ignored; ports unchanged.

Structure
REQ-037 Package xt_ram_bridge_pkg SHALL hold the state enum (IDLE, REQ, HOLD) and constant OPEN_BUS_DATA = 8'hFF.
REQ-038 SHALL be a single module; no sub-module.

Verification
REQ-039 Read at 20'h01234, ram_ack 3 cycles after ram_request with data 8'h5A -> ready low for 4 cycles, data_bus_out=8'h5A with enable=1 until memory_read_n rises.
REQ-040 Write 8'hC3 at 20'h9FFFF -> ram_write=1, ram_write_data=8'hC3, ram_address=20'h9FFFF; write at 20'hA0000 -> no ram_request.
REQ-041 No ram_ack for 255 cycles -> ready returns 1, data_bus_out=8'hFF; an ack at cycle 300 is ignored.
REQ-042 Parity enabled, read data 8'h01 with ram_read_parity=1 -> io_channel_check=1; parity_clear pulse -> 0.
REQ-043 Reset asserted in REQ -> ram_request=0 and io_channel_ready=1 next cycle; both strobes low together -> no ram_request.
